// File: rtl/gol_gen_sequencer.sv
// gol_gen_sequencer
//   Sweeps the Game-of-Life row register file once per start request.
//   Each live row 1..N is replaced in place by its next generation. A
//   three-row window (prev / cur / rd) keeps the original rows that are
//   still needed, so a row is never overwritten before its neighbours
//   have consumed it.
//
// Ports
//   ph2       in   clock, all state changes on its rising edge
//   reset_n   in   asynchronous active-low reset
//   start     in   level request, sampled in IDLE and DONE
//   busy      out  high during LOAD / STEP / LAST
//   done      out  one-cycle pulse after the last row has been written
//   gen_count out  generations completed since reset (wraps)
//   ra        out  register file read address
//   rd        in   register file read data (combinational from ra)
//   regwrite  out  register file write enable
//   wa        out  register file write address
//   wd        out  register file write data
//
// Build option
//   GOL_TORUS_EN : when defined, bit WIDTH-1 and bit 0 are horizontal
//                  neighbours. When undefined, cells beyond the row edge
//                  are dead.
module gol_gen_sequencer #(
    parameter int WIDTH   = 8,
    parameter int REGBITS = 3
) (
    input  logic               ph2,
    input  logic               reset_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [15:0]        gen_count,
    output logic [REGBITS-1:0] ra,
    input  logic [WIDTH-1:0]   rd,
    output logic               regwrite,
    output logic [REGBITS-1:0] wa,
    output logic [WIDTH-1:0]   wd
);

    localparam logic [REGBITS-1:0] ONE_ROW  = REGBITS'(1);
    localparam logic [REGBITS-1:0] ROW_N    = {REGBITS{1'b1}};
    localparam logic [REGBITS-1:0] ROW_PEN  = REGBITS'(ROW_N - ONE_ROW);

    typedef enum logic [2:0] {IDLE, LOAD, STEP, LAST, DONE} state_t;

    state_t             state;
    logic [WIDTH-1:0]   prev;
    logic [WIDTH-1:0]   cur;
    logic [REGBITS-1:0] r;

    // Next generation of row 'mid' given the rows above and below it.
    function automatic logic [WIDTH-1:0] next_row(input logic [WIDTH-1:0] up,
                                                  input logic [WIDTH-1:0] mid,
                                                  input logic [WIDTH-1:0] dn);
        logic [WIDTH+1:0] eu, em, ed;
        logic [3:0]       cnt;
        logic [WIDTH-1:0] res;
        // Pad each row with one cell on either side: index 0 is column -1,
        // index WIDTH+1 is column WIDTH.
`ifdef GOL_TORUS_EN
        eu = {up[0],  up,  up[WIDTH-1]};
        em = {mid[0], mid, mid[WIDTH-1]};
        ed = {dn[0],  dn,  dn[WIDTH-1]};
`else
        eu = {1'b0, up,  1'b0};
        em = {1'b0, mid, 1'b0};
        ed = {1'b0, dn,  1'b0};
`endif
        res = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt = 4'(eu[i]) + 4'(eu[i+1]) + 4'(eu[i+2])
                + 4'(em[i])               + 4'(em[i+2])
                + 4'(ed[i]) + 4'(ed[i+1]) + 4'(ed[i+2]);
            res[i] = (cnt == 4'd3) || (mid[i] && (cnt == 4'd2));
        end
        return res;
    endfunction

    always_ff @(posedge ph2 or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            gen_count <= 16'd0;
            prev      <= '0;
            cur       <= '0;
            r         <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    // Row 1 has nothing above it: prev starts as the dead border.
                    cur   <= rd;
                    prev  <= '0;
                    r     <= ONE_ROW;
                    state <= (REGBITS > 1) ? STEP : LAST;
                end
                STEP: begin
                    prev <= cur;
                    cur  <= rd;
                    r    <= r + ONE_ROW;
                    if (r == ROW_PEN)
                        state <= LAST;
                end
                LAST: begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                DONE: begin
                    gen_count <= gen_count + 16'd1;
                    if (start) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Register file port drive. rd is consumed in the same cycle it is
    // addressed, so every read is one row ahead of the row being written.
    always_comb begin
        ra       = '0;
        regwrite = 1'b0;
        wa       = '0;
        wd       = '0;
        case (state)
            LOAD: ra = ONE_ROW;
            STEP: begin
                ra       = r + ONE_ROW;
                regwrite = 1'b1;
                wa       = r;
                wd       = next_row(prev, cur, rd);
            end
            LAST: begin
                // Row N+1 does not exist; the bottom border is dead.
                regwrite = 1'b1;
                wa       = ROW_N;
                wd       = next_row(prev, cur, '0);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_gol_gen_sequencer.sv
module tb_gol_gen_sequencer;

    localparam int N = 7;
    typedef logic [7:0][7:0] grid_t;

    typedef struct {
        string nm;
        grid_t init;
        grid_t exp;
    } vec_t;

    logic        ph2 = 1'b0;
    logic        reset_n;
    logic        start;
    logic        busy;
    logic        done;
    logic [15:0] gen_count;
    logic [2:0]  ra;
    logic [7:0]  rd;
    logic        regwrite;
    logic [2:0]  wa;
    logic [7:0]  wd;

    grid_t mem;
    grid_t load_img;
    logic  load_req;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] gexp;

    always #5 ph2 = ~ph2;

    gol_gen_sequencer #(.WIDTH(8), .REGBITS(3)) dut (
        .ph2(ph2), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
        .gen_count(gen_count), .ra(ra), .rd(rd), .regwrite(regwrite),
        .wa(wa), .wd(wd)
    );

    // Register file model: row 0 is hardwired zero.
    assign rd = mem[ra];
    always @(posedge ph2) begin
        if (load_req) mem <= load_img;
        else if (regwrite && wa != 3'd0) mem[wa] <= wd;
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: whole-grid Life step from the cell rule.
    function automatic grid_t model_next(input grid_t g);
        grid_t n;
        int cnt, rr, cc;
        n = '0;
        for (int r = 1; r <= N; r++)
            for (int c = 0; c < 8; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (dr == 0 && dc == 0) continue;
                        rr = r + dr;
                        cc = c + dc;
                        if (rr < 1 || rr > N) continue;
`ifdef GOL_TORUS_EN
                        cc = (cc + 8) % 8;
`else
                        if (cc < 0 || cc > 7) continue;
`endif
                        cnt += int'(g[rr][cc]);
                    end
                n[r][c] = (cnt == 3) || (g[r][c] && cnt == 2);
            end
        return n;
    endfunction

    task automatic load(input grid_t g);
        @(negedge ph2);
        load_img    = g;
        load_img[0] = 8'h00;
        load_req    = 1'b1;
        @(negedge ph2);
        load_req = 1'b0;
    endtask

    task automatic cmp_grid(input string nm, input grid_t exp);
        for (int r = 1; r <= N; r++)
            check($sformatf("%s_row%0d", nm, r), 64'(mem[r]), 64'(exp[r]));
    endtask

    // Run ngen generations (start held for all of them). Optionally pulse
    // start for one cycle at cycle pulse_cyc of the first sweep.
    task automatic run_gens(input string nm, input int ngen, input int pulse_cyc);
        int cyc, ndone, wcnt;
        logic [2:0] expwa;
        cyc = 0; ndone = 0; wcnt = 0; expwa = 3'd1;
        start = 1'b1;
        while (ndone < ngen && cyc < ngen * (N + 2) + 20) begin
            @(negedge ph2);
            cyc++;
            check({nm, "_busy_vs_done"}, 64'(busy), 64'(!done));
            if (regwrite) begin
                check({nm, "_wa"}, 64'(wa), 64'(expwa));
                expwa++;
                wcnt++;
            end
            if (done) begin
                ndone++;
                check({nm, "_done_cycle"}, 64'(cyc), 64'(ndone * (N + 2)));
                check({nm, "_write_count"}, 64'(wcnt), 64'(N));
                wcnt = 0;
                expwa = 3'd1;
            end
            if (ngen == 1 && cyc == 1) start = 1'b0;
            if (ndone == ngen) start = 1'b0;
            if (pulse_cyc > 0 && cyc == pulse_cyc) start = 1'b1;
            if (pulse_cyc > 0 && cyc == pulse_cyc + 1) start = 1'b0;
        end
        if (ndone < ngen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got %0d done pulses expected %0d", nm, ndone, ngen);
        end
        start = 1'b0;
        @(negedge ph2);
        gexp = gexp + 16'(ngen);
        check({nm, "_gen_count"}, 64'(gen_count), 64'(gexp));
        check({nm, "_idle_busy"}, 64'(busy), 64'd0);
    endtask

    vec_t  tbl[4];
    grid_t g, e, blk;

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        load_req = 1'b0;
        load_img = '0;
        gexp     = 16'd0;

        tbl[0].nm = "blinker"; tbl[0].init = '0; tbl[0].exp = '0;
        tbl[0].init[2] = 8'h08; tbl[0].init[3] = 8'h08; tbl[0].init[4] = 8'h08;
        tbl[0].exp[3] = 8'h1C;
        tbl[1].nm = "block"; tbl[1].init = '0;
        tbl[1].init[3] = 8'h18; tbl[1].init[4] = 8'h18;
        tbl[1].exp = tbl[1].init;
        tbl[2].nm = "top_border"; tbl[2].init = '0; tbl[2].exp = '0;
        tbl[2].init[1] = 8'h1C;
        tbl[2].exp[1] = 8'h08; tbl[2].exp[2] = 8'h08;
        tbl[3].nm = "edge_wrap"; tbl[3].init = '0; tbl[3].exp = '0;
        tbl[3].init[3] = 8'h83;
`ifdef GOL_TORUS_EN
        tbl[3].exp[2] = 8'h01; tbl[3].exp[3] = 8'h01; tbl[3].exp[4] = 8'h01;
`endif

        repeat (2) @(negedge ph2);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_regwrite", 64'(regwrite), 64'd0);
        check("rst_ra", 64'(ra), 64'd0);
        check("rst_wa", 64'(wa), 64'd0);
        check("rst_wd", 64'(wd), 64'd0);
        check("rst_gen_count", 64'(gen_count), 64'd0);
        reset_n = 1'b1;
        @(negedge ph2);

        for (int i = 0; i < 4; i++) begin
            load(tbl[i].init);
            run_gens(tbl[i].nm, 1, 0);
            cmp_grid(tbl[i].nm, tbl[i].exp);
        end

        // Blinker returns to its original phase after two generations.
        load(tbl[0].init);
        run_gens("blink1", 1, 0);
        run_gens("blink2", 1, 0);
        cmp_grid("blink_restore", tbl[0].init);

        // Block stays put across three back-to-back generations.
        blk = tbl[1].init;
        load(blk);
        run_gens("block3", 3, 0);
        cmp_grid("block3", blk);

        // start pulsed during STEP must not trigger another sweep.
        g = '0;
        for (int r = 1; r <= N; r++) g[r] = 8'($urandom);
        load(g);
        run_gens("pulse", 1, 4);
        repeat (3) begin
            @(negedge ph2);
            check("pulse_no_rerun", 64'(busy), 64'd0);
        end
        check("pulse_grid", 64'(mem), 64'(model_next(g)));

        // Random grids, one to three back-to-back generations each.
        for (int k = 0; k < 20; k++) begin
            int ng;
            g = '0;
            for (int r = 1; r <= N; r++) g[r] = 8'($urandom);
            ng = int'($urandom_range(1, 3));
            e = g;
            for (int j = 0; j < ng; j++) e = model_next(e);
            load(g);
            run_gens($sformatf("rand%0d", k), ng, 0);
            check($sformatf("rand%0d_grid", k), 64'(mem), 64'(e));
        end

        // Reset in STEP with r=3: rows 1..2 already hold the new generation.
        g = '0;
        for (int r = 1; r <= N; r++) g[r] = 8'($urandom);
        load(g);
        start = 1'b1;
        @(negedge ph2);
        start = 1'b0;
        repeat (3) @(negedge ph2);
        check("mid_wa_before", 64'(wa), 64'd3);
        check("mid_regwrite_before", 64'(regwrite), 64'd1);
        reset_n = 1'b0;
        #1;
        check("mid_busy", 64'(busy), 64'd0);
        check("mid_regwrite", 64'(regwrite), 64'd0);
        check("mid_done", 64'(done), 64'd0);
        check("mid_gen_count", 64'(gen_count), 64'd0);
        check("mid_ra", 64'(ra), 64'd0);
        e = g;
        blk = model_next(g);
        e[1] = blk[1];
        e[2] = blk[2];
        cmp_grid("mid_rows", e);
        @(negedge ph2);
        reset_n = 1'b1;
        gexp = 16'd0;
        @(negedge ph2);
        load(tbl[0].init);
        run_gens("post_reset", 1, 0);
        cmp_grid("post_reset", tbl[0].exp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
